// File: rtl/auth_msg_rx_assembler_pkg.sv
// Shared definitions for the authentication receive path: FSM encodings,
// header byte offsets, protocol constants and message-width macros.
`ifndef AUTH_MSG_MAX_BYTES
`define AUTH_MSG_MAX_BYTES 264
`endif
`ifndef AUTH_MSG_W
`define AUTH_MSG_W (`AUTH_MSG_MAX_BYTES*8)
`endif

package auth_msg_rx_assembler_pkg;

  localparam int unsigned AUTH_MAX_MSG_BYTES = `AUTH_MSG_MAX_BYTES;

  localparam int unsigned S_IDLE    = 0;
  localparam int unsigned S_COLLECT = 1;
  localparam int unsigned S_CHECK   = 2;
  localparam int unsigned S_DELIVER = 3;
  localparam int unsigned S_DRAIN   = 4;

  localparam logic [4:0] ST_IDLE    = 5'b00001;
  localparam logic [4:0] ST_COLLECT = 5'b00010;
  localparam logic [4:0] ST_CHECK   = 5'b00100;
  localparam logic [4:0] ST_DELIVER = 5'b01000;
  localparam logic [4:0] ST_DRAIN   = 5'b10000;

  localparam int unsigned HDR_PROTOCOL_VERSION = 0;
  localparam int unsigned HDR_MESSAGE_TYPE     = 1;
  localparam int unsigned HDR_PARAM1           = 2;
  localparam int unsigned HDR_PARAM2           = 3;

  localparam logic [7:0] AUTH_PROTOCOL_VERSION = 8'h01;
  localparam logic [7:0] AUTH_MSG_CERTIFICATE  = 8'h02;

  typedef struct packed {
    logic overflow;
    logic short_len;
    logic header;
    logic timeout;
  } auth_rx_err_t;

endpackage

// File: rtl/auth_rx_timeout_counter.sv
// Inter-byte idle counter for the receive assembler; only present when
// AUTH_RX_TIMEOUT_EN is defined (the default build leaves this file empty).
`ifdef AUTH_RX_TIMEOUT_EN
module auth_rx_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic run_i,
  input  logic clear_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Count idle cycles while running; saturate on the final count.
  always_comb begin
    cnt_d = cnt_q;
    if (!run_i || clear_i) begin
      cnt_d = '0;
    end else if (cnt_q != LAST) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires on the TIMEOUT_CYCLES-th consecutive idle cycle.
  assign expired_o = run_i && !clear_i && (cnt_q == LAST);

endmodule
`endif

// File: rtl/auth_msg_rx_assembler.sv
// Collects PD transport bytes into one MSB-first message vector, validates
// length and protocol version, then hands it over with valid/ack.
// Optional inter-byte timeout: define AUTH_RX_TIMEOUT_EN.
module auth_msg_rx_assembler
  import auth_msg_rx_assembler_pkg::*;
#(
  parameter int unsigned MAX_MSG_BYTES        = 264,
  parameter int unsigned MIN_MSG_BYTES        = 4,
  parameter logic [7:0]  EXP_PROTOCOL_VERSION = 8'h01,
  parameter int unsigned LEN_W                = 9,
  parameter int unsigned TIMEOUT_CYCLES       = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_valid,
  input  logic                       rx_sop,
  input  logic                       rx_eop,
  output logic                       rx_ready,
  output logic [MAX_MSG_BYTES*8-1:0] msg_out,
  output logic [LEN_W-1:0]           msg_len,
  output logic                       msg_valid,
  input  logic                       msg_ack,
  output logic                       busy,
  output logic                       err_overflow,
  output logic                       err_short,
  output logic                       err_header,
  output logic                       err_timeout
);

  localparam int unsigned      MSG_W   = MAX_MSG_BYTES * 8;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_MSG_BYTES);
  localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(MIN_MSG_BYTES);

  logic [4:0]       state_q,   state_d;
  logic [LEN_W-1:0] count_q,   count_d;
  logic [MSG_W-1:0] msg_out_q, msg_out_d;
  logic [LEN_W-1:0] msg_len_q, msg_len_d;
  auth_rx_err_t     err_q,     err_d;

  logic accept_s;
  logic start_s;
  logic timeout_s;

  // Backpressure in CHECK and DELIVER; nothing is accepted while in reset.
  assign rx_ready = !reset && enable &&
                    (state_q[S_IDLE] || state_q[S_COLLECT] || state_q[S_DRAIN]);
  assign accept_s = rx_valid && rx_ready;
  assign start_s  = accept_s && rx_sop && (state_q[S_IDLE] || state_q[S_COLLECT]);

`ifdef AUTH_RX_TIMEOUT_EN
  logic to_run_s;
  assign to_run_s = state_q[S_COLLECT] || state_q[S_DRAIN];

  auth_rx_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .run_i    (to_run_s),
    .clear_i  (accept_s),
    .expired_o(timeout_s)
  );
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state logic: enable drop wins, then an accepted sop restarts.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    msg_out_d = msg_out_q;
    msg_len_d = msg_len_q;
    err_d     = err_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else if (start_s) begin
      msg_out_d               = '0;
      msg_out_d[MSG_W-1 -: 8] = rx_data;
      msg_len_d               = '0;
      err_d                   = '0;
      count_d                 = LEN_W'(1);
      state_d                 = rx_eop ? ST_CHECK : ST_COLLECT;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_COLLECT: begin
          if (timeout_s) begin
            err_d.timeout = 1'b1;
            state_d       = ST_IDLE;
          end else if (accept_s && (count_q == MAX_LEN)) begin
            err_d.overflow = 1'b1;
            state_d        = rx_eop ? ST_IDLE : ST_DRAIN;
          end else if (accept_s) begin
            msg_out_d[MSG_W-1-8*int'(count_q) -: 8] = rx_data;
            count_d = count_q + LEN_W'(1);
            state_d = rx_eop ? ST_CHECK : ST_COLLECT;
          end else begin
            state_d = ST_COLLECT;
          end
        end
        ST_CHECK: begin
          msg_len_d = count_q;
          if (count_q < MIN_LEN) begin
            err_d.short_len = 1'b1;
            state_d         = ST_IDLE;
          end else if (msg_out_q[MSG_W-1-8*HDR_PROTOCOL_VERSION -: 8] != EXP_PROTOCOL_VERSION) begin
            err_d.header = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            state_d = ST_DELIVER;
          end
        end
        ST_DELIVER: begin
          state_d = msg_ack ? ST_IDLE : ST_DELIVER;
        end
        ST_DRAIN: begin
          if (timeout_s) begin
            err_d.timeout = 1'b1;
            state_d       = ST_IDLE;
          end else if (accept_s && rx_eop) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DRAIN;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      msg_out_q <= '0;
      msg_len_q <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      msg_out_q <= msg_out_d;
      msg_len_q <= msg_len_d;
      err_q     <= err_d;
    end
  end

  assign msg_out      = msg_out_q;
  assign msg_len      = msg_len_q;
  assign msg_valid    = state_q[S_DELIVER];
  assign busy         = !state_q[S_IDLE];
  assign err_overflow = err_q.overflow;
  assign err_short    = err_q.short_len;
  assign err_header   = err_q.header;
  assign err_timeout  = err_q.timeout;

endmodule

// File: tb/tb_auth_msg_rx_assembler.sv
// Self-checking bench: directed cases plus randomized messages scored by a
// message-level reference model (length/version rules applied per message).
module tb_auth_msg_rx_assembler;

  localparam int MAXB   = 264;
  localparam int MSG_W  = MAXB * 8;
  localparam int MINB   = 4;
  localparam int TO_CYC = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_sop;
  logic             rx_eop;
  logic             rx_ready;
  logic [MSG_W-1:0] msg_out;
  logic [8:0]       msg_len;
  logic             msg_valid;
  logic             msg_ack;
  logic             busy;
  logic             err_overflow;
  logic             err_short;
  logic             err_header;
  logic             err_timeout;

  int checks = 0;
  int errors = 0;

  logic [MSG_W-1:0] exp_msg;
  int               exp_len;
  logic             exp_ov, exp_sh, exp_hd, exp_to;

  always #5 clk = ~clk;

  auth_msg_rx_assembler #(
    .MAX_MSG_BYTES       (MAXB),
    .MIN_MSG_BYTES       (MINB),
    .EXP_PROTOCOL_VERSION(8'h01),
    .LEN_W               (9),
    .TIMEOUT_CYCLES      (TO_CYC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_sop      (rx_sop),
    .rx_eop      (rx_eop),
    .rx_ready    (rx_ready),
    .msg_out     (msg_out),
    .msg_len     (msg_len),
    .msg_valid   (msg_valid),
    .msg_ack     (msg_ack),
    .busy        (busy),
    .err_overflow(err_overflow),
    .err_short   (err_short),
    .err_header  (err_header),
    .err_timeout (err_timeout)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_start();
    exp_msg = '0;
    exp_len = 0;
    exp_ov  = 1'b0;
    exp_sh  = 1'b0;
    exp_hd  = 1'b0;
    exp_to  = 1'b0;
  endtask

  task automatic check_outputs(input logic ev, input logic eb);
    check_val("msg_valid", 64'(msg_valid), 64'(ev));
    check_val("busy", 64'(busy), 64'(eb));
    check_val("msg_len", 64'(msg_len), 64'(exp_len));
    check_val("err_overflow", 64'(err_overflow), 64'(exp_ov));
    check_val("err_short", 64'(err_short), 64'(exp_sh));
    check_val("err_header", 64'(err_header), 64'(exp_hd));
    check_val("err_timeout", 64'(err_timeout), 64'(exp_to));
    for (int k = 0; k < MAXB; k++) begin
      check_val($sformatf("msg_out[%0d]", k),
                64'(msg_out[MSG_W-1-8*k -: 8]), 64'(exp_msg[MSG_W-1-8*k -: 8]));
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic sop, input logic eop);
    int waited;
    waited   = 0;
    rx_data  = d;
    rx_sop   = sop;
    rx_eop   = eop;
    rx_valid = 1'b1;
    while (!rx_ready && waited < 50) begin
      tick();
      waited++;
    end
    if (!rx_ready) check_val("rx_ready_wait", 64'(rx_ready), 64'd1);
    tick();
    rx_valid = 1'b0;
    rx_sop   = 1'b0;
    rx_eop   = 1'b0;
  endtask

  // Send a complete sop..eop message and score the outcome at message level.
  task automatic run_msg(input logic [7:0] q[$], input bit gaps);
    int n;
    n = q.size();
    model_start();
    for (int k = 0; k < n; k++) begin
      send_byte(q[k], k == 0, k == n - 1);
      if (k < MAXB) exp_msg[MSG_W-1-8*k -: 8] = q[k];
      if (gaps && k != n - 1) repeat ($urandom_range(0, 2)) tick();
    end
    if (n > MAXB) begin
      exp_ov = 1'b1;
      check_outputs(1'b0, 1'b0);
    end else begin
      check_val("busy_after_eop", 64'(busy), 64'd1);
      check_val("valid_after_eop", 64'(msg_valid), 64'd0);
      tick();
      exp_len = n;
      if (n < MINB) begin
        exp_sh = 1'b1;
        check_outputs(1'b0, 1'b0);
      end else if (q[0] != 8'h01) begin
        exp_hd = 1'b1;
        check_outputs(1'b0, 1'b0);
      end else begin
        check_outputs(1'b1, 1'b1);
        check_val("rx_ready_deliver", 64'(rx_ready), 64'd0);
        repeat ($urandom_range(0, 3)) begin
          tick();
          check_val("valid_hold", 64'(msg_valid), 64'd1);
        end
        msg_ack = 1'b1;
        tick();
        msg_ack = 1'b0;
        check_outputs(1'b0, 1'b0);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q[$];
    reset    = 1'b1;
    enable   = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    rx_sop   = 1'b0;
    rx_eop   = 1'b0;
    msg_ack  = 1'b0;
    repeat (3) tick();
    model_start();
    check_val("rx_ready_in_reset", 64'(rx_ready), 64'd0);
    check_outputs(1'b0, 1'b0);
    reset = 1'b0;
    tick();
    check_val("rx_ready_idle", 64'(rx_ready), 64'd1);

    // 12-byte certificate-style message
    q = {8'h01, 8'h02, 8'h00, 8'h00};
    for (int i = 0; i < 8; i++) q.push_back(8'hAA + 8'(i));
    run_msg(q, 1'b0);

    // short message, then next sop clears the sticky error
    q = {8'h01, 8'h02, 8'h00};
    run_msg(q, 1'b0);
    send_byte(8'h01, 1'b1, 1'b0);
    check_val("short_cleared_by_sop", 64'(err_short), 64'd0);
    enable = 1'b0;
    tick();
    enable = 1'b1;

    // wrong protocol version
    q = {8'h02, 8'h02, 8'h00, 8'h00};
    run_msg(q, 1'b0);

    // overflow: MAX+5 bytes
    q = {};
    for (int i = 0; i < MAXB + 5; i++) q.push_back(8'($urandom_range(0, 255)));
    q[0] = 8'h01;
    run_msg(q, 1'b0);

    // sop mid-message after 6 bytes, then a 10-byte message
    for (int i = 0; i < 6; i++) send_byte(8'h01 + 8'(i), i == 0, 1'b0);
    q = {8'h01, 8'h02, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    run_msg(q, 1'b0);

    // enable dropped in COLLECT keeps the partial buffer, no error
    model_start();
    for (int i = 0; i < 5; i++) begin
      send_byte(8'h01 + 8'(3 * i), i == 0, 1'b0);
      exp_msg[MSG_W-1-8*i -: 8] = 8'h01 + 8'(3 * i);
    end
    enable = 1'b0;
    tick();
    check_val("rx_ready_disabled", 64'(rx_ready), 64'd0);
    check_outputs(1'b0, 1'b0);
    enable = 1'b1;

    // stall after byte 3
    model_start();
    q = {8'h01, 8'h02, 8'h00};
    for (int i = 0; i < 3; i++) begin
      send_byte(q[i], i == 0, 1'b0);
      exp_msg[MSG_W-1-8*i -: 8] = q[i];
    end
    repeat (TO_CYC + 4) tick();
`ifdef AUTH_RX_TIMEOUT_EN
    exp_to = 1'b1;
    check_outputs(1'b0, 1'b0);
`else
    check_outputs(1'b0, 1'b1);
    enable = 1'b0;
    tick();
    enable = 1'b1;
    check_outputs(1'b0, 1'b0);
`endif

    // reset mid-message discards everything
    for (int i = 0; i < 4; i++) send_byte(8'h01, i == 0, 1'b0);
    reset = 1'b1;
    tick();
    check_val("rx_ready_mid_reset", 64'(rx_ready), 64'd0);
    reset = 1'b0;
    model_start();
    check_outputs(1'b0, 1'b0);

    // randomized messages with stray non-sop bytes in IDLE
    for (int m = 0; m < 40; m++) begin
      int sel;
      int len;
      if ($urandom_range(0, 3) == 0) begin
        send_byte(8'($urandom_range(0, 255)), 1'b0, 1'($urandom_range(0, 1)));
        check_outputs(1'b0, 1'b0);
      end
      sel = $urandom_range(0, 9);
      if (sel == 0)      len = $urandom_range(1, 3);
      else if (sel == 1) len = $urandom_range(MAXB - 1, MAXB + 3);
      else               len = $urandom_range(4, 24);
      q = {};
      for (int i = 0; i < len; i++) q.push_back(8'($urandom_range(0, 255)));
      if ($urandom_range(0, 3) != 0) q[0] = 8'h01;
      run_msg(q, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
